pipelined_mac_acc: RTL and testbench
====================================

# pipelined_mac_acc

Parametrised, fully pipelined unsigned multiply-accumulate unit. It generalises our fixed 4×4 pipelined array MAC to arbitrary operand and accumulator widths and adds a real accumulator with per-sample valid tagging, accumulator clear and sticky overflow. It accepts one operand pair per clock, with no backpressure, and feeds filter and dot-product datapaths downstream.

## Interface
- `DATA_W`, default 4: operand width in bits. Legal range 2..16.
- `ACC_W`, default 10: accumulator and output width in bits. Must satisfy ACC_W ≥ 2·DATA_W.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high. Clears all pipeline and accumulator state immediately.
- `in_valid` input, 1 bit: `a`/`y` hold a sample to be accepted this cycle.
- `clr` input, 1 bit: qualified by `in_valid`. The product of this sample replaces the accumulator instead of being added to it.
- `a` input, DATA_W bits: multiplicand, unsigned.
- `y` input, DATA_W bits: multiplier, unsigned.
- `out_valid` output, 1 bit: one-cycle pulse per accumulated sample.
- `out` output, ACC_W bits: accumulator value; holds between pulses.
- `overflow` output, 1 bit: sticky; set when any accumulate exceeded 2^ACC_W − 1.

## Operation
- **Multiplier pipeline.** DATA_W partial-product stages.
  - Stage k (k = 1..DATA_W) adds (a AND y[k−1]) << (k−1) into a 2·DATA_W-bit running partial sum.
  - `a`, the unconsumed `y` bits, the valid tag and the clr tag are registered alongside the partial sum in every stage.
  - Each stage is registered and carries no feedback.
- **Accumulate stage.** Stage DATA_W+1. When the incoming tag is valid:
  - If clr: acc ← zero-extended product; overflow ← 0.
  - Otherwise: acc ← acc + product, computed at ACC_W+1 bits. If bit ACC_W is set, overflow ← 1 and acc ← the low ACC_W bits (wrap).
- **Invalid slots.** An invalid tag leaves acc and overflow unchanged and keeps out_valid at 0. Bubbles from in_valid = 0 propagate through the pipeline without disturbing state.
- **clr without data.** clr with in_valid = 0 is ignored. It is not latched.
- **Back-to-back samples.** Samples entering on consecutive cycles are each accumulated in order. A clr sample inside a burst restarts accumulation at exactly that sample.
- **Throughput.** One sample per clock, sustained indefinitely.
- **Reset values.**
  - out = 0, out_valid = 0, overflow = 0.
  - All pipeline valid tags = 0.
  - Asserting reset mid-stream discards all in-flight samples. After release, the first accepted sample accumulates onto 0.

## Timing
- Latency is DATA_W+1 clocks. A sample accepted at rising edge t produces out and out_valid updated by edge t+DATA_W+1. With the defaults, that is 5 clocks.
- out_valid is high for exactly one cycle per valid sample. For N consecutive valid samples it is high for N consecutive cycles.
- overflow changes in the same cycle as the out update that causes the overflow or clears it.
- Reset deassertion is synchronised externally. The first accept is allowed on the first rising edge after release.
- Critical path:
  - Multiplier stages: one DATA_W+k-bit add per stage.
  - Accumulate stage: one ACC_W+1-bit add.

## Configuration
- Macro: `PIPELINED_MAC_SATURATE_EN`.
- **Defined.** On an accumulate that exceeds 2^ACC_W − 1:
  - acc clamps to all-ones (2^ACC_W − 1) and stays clamped for later non-clr samples.
  - overflow still sets.
  - A clr sample is the only way to leave saturation, other than reset.
- **Undefined.** Modular wrap as described in Operation.
- The clr, overflow and latency behaviour is identical in both builds.

## Test plan
All scenarios use DATA_W = 4, ACC_W = 10.
- **Reset values:** Assert reset mid-stream with 3 samples in flight → out = 0, out_valid = 0 and overflow = 0 immediately; no out_valid pulses after release until a new sample is accepted.
- **Single product and latency:** a = 13, y = 11, clr = 1 at edge t → out = 143 with out_valid high at edge t+5 only.
- **Accumulate with bubbles:** Samples (3,5,clr), (2,7), bubble, (15,1) → out_valid pulses with values 15, 29, 44; out holds 44 afterwards.
- **Wrap:** Five back-to-back (15,15) samples, the first with clr → out = 225, 450, 675, 900, 101, and overflow rises with the 101 result.
  - With PIPELINED_MAC_SATURATE_EN, the fifth result is 1023 and overflow = 1.
- **clr clears overflow:** Following the wrap scenario, send (1,1,clr) → out = 1 and overflow = 0 in the same cycle.
- **Ignored clr:** clr = 1 with in_valid = 0, between (2,2,clr) and (3,3) → results 4 then 13; the accumulator is not cleared.

Source files
------------

// File: rtl/pipelined_mac_acc_if.sv
// Sample/result bundle for pipelined_mac_acc; the master drives samples and the slave returns
// accumulated results.
interface pipelined_mac_acc_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 10
);
  logic              in_valid;
  logic              clr;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] y;
  logic              out_valid;
  logic [ACC_W-1:0]  out;
  logic              overflow;

  modport master (
    output in_valid, clr, a, y,
    input  out_valid, out, overflow
  );

  modport slave (
    input  in_valid, clr, a, y,
    output out_valid, out, overflow
  );
endinterface

// File: rtl/pipelined_mac_acc.sv
// Fully pipelined unsigned shift-add MAC with tagged accumulator, clear and sticky overflow.
// Define PIPELINED_MAC_SATURATE_EN to clamp the accumulator instead of wrapping.
module pipelined_mac_acc #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 10
) (
  input logic                clk,
  input logic                reset,
  pipelined_mac_acc_if.slave bus
);
  localparam int unsigned PW = 2 * DATA_W;

  // Index 0 is the input register; index k holds the state after partial-product stage k.
  logic [DATA_W-1:0] a_q  [DATA_W];
  logic [DATA_W-1:0] y_q  [DATA_W];
  logic [PW-1:0]     ps_q [DATA_W+1];
  logic [DATA_W:0]   v_q;
  logic [DATA_W:0]   c_q;
  logic [PW-1:0]     pp   [DATA_W];

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q;
  logic [ACC_W:0]    sum;

  always_comb begin
    for (int k = 0; k < DATA_W; k++) begin
      pp[k] = PW'(a_q[k] & {DATA_W{y_q[k][0]}}) << k;
    end
  end

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    sum   = {1'b0, acc_q} + (ACC_W + 1)'(ps_q[DATA_W]);
    if (v_q[DATA_W]) begin
      if (c_q[DATA_W]) begin
        acc_d = ACC_W'(ps_q[DATA_W]);
        ovf_d = 1'b0;
      end else if (sum[ACC_W]) begin
        ovf_d = 1'b1;
`ifdef PIPELINED_MAC_SATURATE_EN
        acc_d = '1;
`else
        acc_d = sum[ACC_W-1:0];
`endif
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DATA_W; k++) begin
        a_q[k] <= '0;
        y_q[k] <= '0;
      end
      for (int k = 0; k <= DATA_W; k++) begin
        ps_q[k] <= '0;
      end
      v_q         <= '0;
      c_q         <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q[0]  <= bus.a;
      y_q[0]  <= bus.y;
      ps_q[0] <= '0;
      // clr only travels with a valid sample, so a bare clr never reaches the accumulator.
      v_q[0]  <= bus.in_valid;
      c_q[0]  <= bus.in_valid & bus.clr;
      for (int k = 1; k < DATA_W; k++) begin
        a_q[k] <= a_q[k-1];
        y_q[k] <= y_q[k-1] >> 1;
      end
      for (int k = 1; k <= DATA_W; k++) begin
        ps_q[k] <= ps_q[k-1] + pp[k-1];
      end
      v_q[DATA_W:1] <= v_q[DATA_W-1:0];
      c_q[DATA_W:1] <= c_q[DATA_W-1:0];
      acc_q         <= acc_d;
      ovf_q         <= ovf_d;
      out_valid_q   <= v_q[DATA_W];
    end
  end

  assign bus.out       = acc_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_pipelined_mac_acc.sv
// Scoreboard bench for pipelined_mac_acc at DATA_W = 4, ACC_W = 10.
module tb_pipelined_mac_acc;
  typedef struct {
    logic [9:0] out;
    logic       ovf;
    int         cyc;
  } res_t;

`ifdef PIPELINED_MAC_SATURATE_EN
  localparam int WrapRes = 1023;
  localparam int MidRes  = 1023;
`else
  localparam int WrapRes = 101;
  localparam int MidRes  = 114;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   nvec  = 0;
  int   nfail = 0;
  res_t sb[$];
  res_t obs[$];

  pipelined_mac_acc_if #(.DATA_W(4), .ACC_W(10)) bus ();

  pipelined_mac_acc #(.DATA_W(4), .ACC_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records every result pulse; samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) obs.push_back('{bus.out, bus.overflow, cyc});
  end

  // A sample set up here is accepted at the next rising edge and its result is due 5 edges later.
  task automatic drive(input bit v, input bit c, input int av, input int yv, input bit push,
                       input int e, input bit eo);
    @(negedge clk);
    bus.in_valid = v;
    bus.clr      = c;
    bus.a        = 4'(av);
    bus.y        = 4'(yv);
    if (v && push) sb.push_back('{10'(e), eo, cyc + 6});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nvec += 3;
    if (bus.out !== 10'd0) begin
      nfail++; $display("FAIL reset out: got %0d expected 0", bus.out);
    end
    if (bus.out_valid !== 1'b0) begin
      nfail++; $display("FAIL reset out_valid: got %0b expected 0", bus.out_valid);
    end
    if (bus.overflow !== 1'b0) begin
      nfail++; $display("FAIL reset overflow: got %0b expected 0", bus.overflow);
    end
    reset = 1'b0;
    idle(6);
    nvec++;
    if (obs.size() != 0) begin
      nfail++; $display("FAIL reset idle pulses: got %0d expected 0", obs.size());
    end
    obs.delete();
  endtask

  task automatic test_single();
    res_t r, o;
    drive(1'b1, 1'b1, 13, 11, 1'b1, 143, 1'b0);
    idle(8);
    nvec++;
    if (obs.size() != sb.size()) begin
      nfail++; $display("FAIL single count: got %0d expected %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      r = sb.pop_front(); o = obs.pop_front(); nvec++;
      if (o.out !== r.out || o.ovf !== r.ovf || o.cyc !== r.cyc) begin
        nfail++;
        $display("FAIL single result: got out=%0d ovf=%0b cyc=%0d expected out=%0d ovf=%0b cyc=%0d",
                 o.out, o.ovf, o.cyc, r.out, r.ovf, r.cyc);
      end
    end
    sb.delete(); obs.delete();
  endtask

  task automatic test_bubbles();
    res_t r, o;
    drive(1'b1, 1'b1, 3, 5, 1'b1, 15, 1'b0);
    drive(1'b1, 1'b0, 2, 7, 1'b1, 29, 1'b0);
    drive(1'b0, 1'b0, 9, 9, 1'b1, 0, 1'b0);
    drive(1'b1, 1'b0, 15, 1, 1'b1, 44, 1'b0);
    idle(8);
    nvec++;
    if (obs.size() != sb.size()) begin
      nfail++; $display("FAIL bubbles count: got %0d expected %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      r = sb.pop_front(); o = obs.pop_front(); nvec++;
      if (o.out !== r.out || o.ovf !== r.ovf || o.cyc !== r.cyc) begin
        nfail++;
        $display("FAIL bubbles result: got out=%0d ovf=%0b cyc=%0d expected out=%0d ovf=%0b cyc=%0d",
                 o.out, o.ovf, o.cyc, r.out, r.ovf, r.cyc);
      end
    end
    sb.delete(); obs.delete();
    nvec++;
    if (bus.out !== 10'd44 || bus.out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL bubbles hold: got out=%0d valid=%0b expected out=44 valid=0",
               bus.out, bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    res_t r, o;
    drive(1'b1, 1'b1, 15, 15, 1'b1, 225, 1'b0);
    drive(1'b1, 1'b0, 15, 15, 1'b1, 450, 1'b0);
    drive(1'b1, 1'b0, 15, 15, 1'b1, 675, 1'b0);
    drive(1'b1, 1'b0, 15, 15, 1'b1, 900, 1'b0);
    drive(1'b1, 1'b0, 15, 15, 1'b1, WrapRes, 1'b1);
    idle(8);
    nvec++;
    if (obs.size() != sb.size()) begin
      nfail++; $display("FAIL wrap count: got %0d expected %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      r = sb.pop_front(); o = obs.pop_front(); nvec++;
      if (o.out !== r.out || o.ovf !== r.ovf || o.cyc !== r.cyc) begin
        nfail++;
        $display("FAIL wrap result: got out=%0d ovf=%0b cyc=%0d expected out=%0d ovf=%0b cyc=%0d",
                 o.out, o.ovf, o.cyc, r.out, r.ovf, r.cyc);
      end
    end
    sb.delete(); obs.delete();
  endtask

  task automatic test_clr_ovf();
    res_t r, o;
    nvec++;
    if (bus.overflow !== 1'b1) begin
      nfail++; $display("FAIL sticky overflow: got %0b expected 1", bus.overflow);
    end
    drive(1'b1, 1'b1, 1, 1, 1'b1, 1, 1'b0);
    idle(8);
    nvec++;
    if (obs.size() != sb.size()) begin
      nfail++; $display("FAIL clr_ovf count: got %0d expected %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      r = sb.pop_front(); o = obs.pop_front(); nvec++;
      if (o.out !== r.out || o.ovf !== r.ovf || o.cyc !== r.cyc) begin
        nfail++;
        $display("FAIL clr_ovf result: got out=%0d ovf=%0b cyc=%0d expected out=%0d ovf=%0b cyc=%0d",
                 o.out, o.ovf, o.cyc, r.out, r.ovf, r.cyc);
      end
    end
    sb.delete(); obs.delete();
  endtask

  task automatic test_ignored_clr();
    res_t r, o;
    drive(1'b1, 1'b1, 2, 2, 1'b1, 4, 1'b0);
    drive(1'b0, 1'b1, 7, 7, 1'b1, 0, 1'b0);
    drive(1'b1, 1'b0, 3, 3, 1'b1, 13, 1'b0);
    idle(8);
    nvec++;
    if (obs.size() != sb.size()) begin
      nfail++; $display("FAIL ignored_clr count: got %0d expected %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      r = sb.pop_front(); o = obs.pop_front(); nvec++;
      if (o.out !== r.out || o.ovf !== r.ovf || o.cyc !== r.cyc) begin
        nfail++;
        $display("FAIL ignored_clr result: got out=%0d ovf=%0b cyc=%0d expected out=%0d ovf=%0b cyc=%0d",
                 o.out, o.ovf, o.cyc, r.out, r.ovf, r.cyc);
      end
    end
    sb.delete(); obs.delete();
  endtask

  task automatic test_mid_reset();
    res_t r, o;
    // Accumulator holds 13 from the previous scenario.
    drive(1'b1, 1'b0, 15, 15, 1'b1, 238, 1'b0);
    drive(1'b1, 1'b0, 15, 15, 1'b1, 463, 1'b0);
    drive(1'b1, 1'b0, 15, 15, 1'b1, 688, 1'b0);
    drive(1'b1, 1'b0, 15, 15, 1'b1, 913, 1'b0);
    drive(1'b1, 1'b0, 15, 15, 1'b1, MidRes, 1'b1);
    idle(8);
    nvec++;
    if (obs.size() != sb.size()) begin
      nfail++; $display("FAIL preload count: got %0d expected %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      r = sb.pop_front(); o = obs.pop_front(); nvec++;
      if (o.out !== r.out || o.ovf !== r.ovf || o.cyc !== r.cyc) begin
        nfail++;
        $display("FAIL preload result: got out=%0d ovf=%0b cyc=%0d expected out=%0d ovf=%0b cyc=%0d",
                 o.out, o.ovf, o.cyc, r.out, r.ovf, r.cyc);
      end
    end
    sb.delete(); obs.delete();
    repeat (4) drive(1'b1, 1'b0, 1, 1, 1'b0, 0, 1'b0);
    #2 reset = 1'b1;
    #1;
    nvec += 3;
    if (bus.out !== 10'd0) begin
      nfail++; $display("FAIL mid_reset out: got %0d expected 0", bus.out);
    end
    if (bus.out_valid !== 1'b0) begin
      nfail++; $display("FAIL mid_reset out_valid: got %0b expected 0", bus.out_valid);
    end
    if (bus.overflow !== 1'b0) begin
      nfail++; $display("FAIL mid_reset overflow: got %0b expected 0", bus.overflow);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(10);
    nvec++;
    if (obs.size() != 0) begin
      nfail++; $display("FAIL mid_reset stale pulses: got %0d expected 0", obs.size());
    end
    obs.delete();
    drive(1'b1, 1'b0, 2, 3, 1'b1, 6, 1'b0);
    idle(8);
    nvec++;
    if (obs.size() != sb.size()) begin
      nfail++; $display("FAIL post_reset count: got %0d expected %0d", obs.size(), sb.size());
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      r = sb.pop_front(); o = obs.pop_front(); nvec++;
      if (o.out !== r.out || o.ovf !== r.ovf || o.cyc !== r.cyc) begin
        nfail++;
        $display("FAIL post_reset result: got out=%0d ovf=%0b cyc=%0d expected out=%0d ovf=%0b cyc=%0d",
                 o.out, o.ovf, o.cyc, r.out, r.ovf, r.cyc);
      end
    end
    sb.delete(); obs.delete();
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.clr      = 1'b0;
    bus.a        = '0;
    bus.y        = '0;
    test_reset();
    test_single();
    test_bubbles();
    test_wrap();
    test_clr_ovf();
    test_ignored_clr();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
